// File: rtl/regfile_read_bypass_if.sv
// rtl/regfile_read_bypass_if.sv - write port and two read ports of the register file
interface regfile_read_bypass_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en_a;
    logic [AW-1:0]    rd_addr_a;
    logic             rd_en_b;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic             rd_valid_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_valid_b;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
    );
endinterface

// File: rtl/regfile_read_bypass.sv
// rtl/regfile_read_bypass.sv - 2R1W register file with registered reads, write bypass and zero register
module regfile_read_bypass #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_read_bypass_if.slave bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] data_a_q;
    logic [WIDTH-1:0] data_b_q;
    logic             valid_a_q;
    logic             valid_b_q;

    // Storage update; writes aimed at the zero entry are dropped so it stays 0 forever.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != ZERO_IDX)) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Port A read select: zero register wins, then same-cycle write bypass, then storage.
    always_comb begin
        sel_a = mem[bus.rd_addr_a];
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
            sel_a = bus.wr_data;
        end
        if (bus.rd_addr_a == ZERO_IDX) begin
            sel_a = '0;
        end
    end

    // Port B read select, same priority as port A.
    always_comb begin
        sel_b = mem[bus.rd_addr_b];
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
            sel_b = bus.wr_data;
        end
        if (bus.rd_addr_b == ZERO_IDX) begin
            sel_b = '0;
        end
    end

    // Port A output register: capture on request, hold data while stalled, valid pulses one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_a_q  <= '0;
            valid_a_q <= 1'b0;
        end else begin
            valid_a_q <= bus.rd_en_a;
            if (bus.rd_en_a) begin
                data_a_q <= sel_a;
            end
        end
    end

    // Port B output register, same behaviour as port A.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_b_q  <= '0;
            valid_b_q <= 1'b0;
        end else begin
            valid_b_q <= bus.rd_en_b;
            if (bus.rd_en_b) begin
                data_b_q <= sel_b;
            end
        end
    end

    assign bus.rd_data_a  = data_a_q;
    assign bus.rd_valid_a = valid_a_q;
    assign bus.rd_data_b  = data_b_q;
    assign bus.rd_valid_b = valid_b_q;
endmodule

// File: doc/regfile_read_bypass.md
Name: regfile_read_bypass

Overview:
- Register file for the 5-stage datapath: 32 entries of 64 bits, one write port driven from writeback, two read ports feeding the decode/register-read stage.
- Each read port is registered, so data appears one cycle after the read request. A write and a read of the same entry in the same cycle returns the new data.
- Entry 31 is the zero register (XZR): it always reads as 0 and ignores writes.
- Each read port holds its last value while not enabled, so decode can stall without losing operands.

Parameters:
- WIDTH, 64, data width of each entry and read/write data.
- DEPTH, 32, number of entries; must be a power of two and at least 2.
- ZERO_REG, 31, index of the hard-wired zero entry.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable for the writeback port.
- wr_addr  input  $clog2(DEPTH)  write entry index.
- wr_data  input  WIDTH  write data.
- rd_en_a  input  1  read request, port A.
- rd_addr_a  input  $clog2(DEPTH)  read index, port A.
- rd_en_b  input  1  read request, port B.
- rd_addr_b  input  $clog2(DEPTH)  read index, port B.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_valid_a  output  1  high for one cycle when rd_data_a holds data from a request made in the previous cycle.
- rd_data_b  output  WIDTH  registered read data, port B.
- rd_valid_b  output  1  high for one cycle when rd_data_b holds data from a request made in the previous cycle.

Behaviour:
- Reset (reset==0, asynchronous assert, synchronous-safe deassert):
  - All entries clear to 0.
  - rd_data_a and rd_data_b clear to 0.
  - rd_valid_a and rd_valid_b clear to 0.
  - Reset asserted mid-operation discards any in-flight write and read immediately.
- Write:
  - On a rising edge with wr_en==1 and wr_addr!=ZERO_REG, entry[wr_addr] <= wr_data.
  - A write with wr_addr==ZERO_REG is dropped silently.
  - An entry not written holds its value indefinitely.
- Read (each port independent, identical rules):
  - On a rising edge with rd_en==1, rd_data <= selected value and rd_valid <= 1.
  - Selected value, in priority order:
    - 0 when rd_addr==ZERO_REG.
    - wr_data when wr_en==1 and wr_addr==rd_addr (bypass).
    - entry[rd_addr] otherwise.
  - Latency: exactly one cycle from the request edge to data/valid.
  - On a rising edge with rd_en==0, rd_data holds its previous value (stall hold) and rd_valid <= 0.
- Simultaneous events:
  - Both ports may read the same entry, including the one being written; both bypass.
  - Read-before-write ordering never exposes stale data for the same-cycle write address.
- Width rules:
  - Addresses are unsigned; no out-of-range case exists because DEPTH is a power of two.
  - Data is passed through unmodified, with no sign handling.
- No combinational path from any input to any output.

Test Plan:
- Reset then read: reset low for 2 cycles, release; rd_en_a=1, rd_addr_a=5 -> next cycle rd_data_a=0, rd_valid_a=1; entries 0..30 all read 0.
- Write then read:
  - Cycle 1: wr_en=1, wr_addr=3, wr_data=64'hDEAD_BEEF_0000_0250.
  - Cycle 2: rd_en_b=1, rd_addr_b=3.
  - Required: cycle 3 has rd_data_b=64'hDEAD_BEEF_0000_0250 and rd_valid_b=1.
- Bypass: same edge wr_en=1, wr_addr=7, wr_data=150, rd_en_a=1, rd_addr_a=7, rd_en_b=1, rd_addr_b=7 -> next cycle rd_data_a=150 and rd_data_b=150; a later read of entry 7 also returns 150.
- Zero register:
  - Write wr_addr=31, wr_data=240.
  - Read rd_addr_a=31 in the same cycle -> rd_data_a=0.
  - Read rd_addr_a=31 in a later cycle -> rd_data_a=0.
- Stall hold: read entry 3 (value 60) with rd_en_a=1, then drop rd_en_a for 3 cycles while writing entry 3 to 70 -> rd_data_a stays 60 and rd_valid_a=0 for those 3 cycles; re-enable -> 70.
- Reset mid-operation: with entry 3=70 and rd_en_a=1 pending, pulse reset low between clock edges -> rd_data_a=0 and rd_valid_a=0 immediately; after release, entry 3 reads 0.
